bcd_conv_scheduler: RTL

- Shares one iterative shift-add-3 (double-dabble) binary-to-BCD engine between NREQ requesters, e.g. the seconds, minutes, hours and date counters of the RTC.
- Round-robin arbitration with a req/ack handshake on the input side.
- Each result is emitted as a one-cycle valid pulse tagged with the requester ID, for capture by the display/scan logic.

---
 rtl/bcd_conv_scheduler.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/bcd_conv_scheduler.sv
// -----------------------------------------------------------------------------
// bcd_conv_scheduler
//
// Shares one iterative shift-add-3 (double-dabble) binary-to-BCD engine between
// NREQ requesters. Requests are granted round robin with a req/ack handshake.
// Each result is emitted as a one-cycle bcd_valid pulse tagged with the
// requester ID.
//
// Optional feature macro: BCD_LEADING_BLANK_EN
//   When defined, leading zero digits above the ones digit are replaced by 4'hF
//   (the blank code for the segment decoder). Overflowed results are not blanked.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   req       in   [NREQ]        per-requester conversion request (level)
//   bin_in    in   [NREQ*BIN_W]  operands, requester i at [i*BIN_W +: BIN_W]
//   ack       out  [NREQ]        one-hot pulse: operand of requester i captured
//   busy      out                engine not idle
//   bcd_valid out                one-cycle pulse: result available
//   bcd_id    out  [ID_W]        requester index of the current result
//   bcd_out   out  [DIGITS*4]    packed BCD result, digit k at [k*4 +: 4]
//   ovf       out                operand exceeded 10^DIGITS-1 (with bcd_valid)
// -----------------------------------------------------------------------------
module bcd_conv_scheduler #(
   parameter int unsigned NREQ   = 4,
   parameter int unsigned BIN_W  = 12,
   parameter int unsigned DIGITS = 4,
   parameter int unsigned ID_W   = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ*BIN_W-1:0]  bin_in,
   output logic [NREQ-1:0]        ack,
   output logic                   busy,
   output logic                   bcd_valid,
   output logic [ID_W-1:0]        bcd_id,
   output logic [DIGITS*4-1:0]    bcd_out,
   output logic                   ovf
);

   localparam int unsigned CntW = $clog2(BIN_W + 1);
   localparam int unsigned BcdW = DIGITS * 4;

   function automatic logic [63:0] max_val();
      logic [63:0] v;
      v = 64'd1;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         v = v * 64'd10;
      end
      return v - 64'd1;
   endfunction

   localparam logic [63:0] MaxVal = max_val();

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e            state_q, state_d;
   logic [ID_W-1:0]   ptr_q;
   logic [ID_W-1:0]   id_q;
   logic [ID_W-1:0]   bcd_id_q;
   logic [CntW-1:0]   cnt_q;
   logic [BIN_W-1:0]  bin_q;
   logic [BcdW-1:0]   bcd_q;
   logic [BcdW-1:0]   out_q;
   logic              ovf_q;
   logic [NREQ-1:0]   ack_q;

   logic              grant_vld;
   logic [ID_W-1:0]   grant_idx;
   logic [BIN_W-1:0]  grant_op;
   int unsigned       idx;
   logic [NREQ-1:0]   req_sh;

   logic [BcdW-1:0]   bcd_adj;
   logic [BcdW-1:0]   bcd_sh;
   logic [BIN_W-1:0]  bin_sh;
   logic [BcdW-1:0]   fmt;
   logic              last_shift;

   // Round-robin search starting just above the last granted index.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      idx       = 0;
      req_sh    = '0;
      for (int unsigned i = 1; i <= NREQ; i++) begin
         idx    = (32'(ptr_q) + i) % NREQ;
         req_sh = req >> idx;
         if (!grant_vld && req_sh[0]) begin
            grant_vld = 1'b1;
            grant_idx = ID_W'(idx);
         end
      end
   end

   assign grant_op   = bin_in[grant_idx*BIN_W +: BIN_W];
   assign last_shift = (cnt_q == CntW'(1));

   // One double-dabble step: add 3 to every digit >= 5, then shift left.
   always_comb begin
      bcd_adj = bcd_q;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         if (bcd_q[k*4 +: 4] >= 4'd5) begin
            bcd_adj[k*4 +: 4] = bcd_q[k*4 +: 4] + 4'd3;
         end
      end
      {bcd_sh, bin_sh} = {bcd_adj, bin_q} << 1;
   end

   // Presentation of the final result.
   always_comb begin
      fmt = bcd_sh;
`ifdef BCD_LEADING_BLANK_EN
      begin
         logic blank;
         blank = 1'b1;
         for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
            if (blank && (fmt[k*4 +: 4] == 4'd0)) begin
               fmt[k*4 +: 4] = 4'hF;
            end else begin
               blank = 1'b0;
            end
         end
      end
`else
`endif
      if (ovf_q) begin
         fmt = {DIGITS{4'h9}};
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (grant_vld) state_d = StShift;
         StShift: if (last_shift) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs.
   always_comb begin
      busy      = (state_q != StIdle);
      bcd_valid = (state_q == StDone);
      ovf       = (state_q == StDone) && ovf_q;
      ack       = ack_q;
      bcd_out   = out_q;
      bcd_id    = bcd_id_q;
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q    <= ID_W'(NREQ - 1);
         id_q     <= '0;
         bcd_id_q <= '0;
         cnt_q    <= '0;
         bin_q    <= '0;
         bcd_q    <= '0;
         out_q    <= '0;
         ovf_q    <= 1'b0;
         ack_q    <= '0;
      end else begin
         ack_q <= '0;
         unique case (state_q)
            StIdle: begin
               if (grant_vld) begin
                  bin_q <= grant_op;
                  bcd_q <= '0;
                  id_q  <= grant_idx;
                  ptr_q <= grant_idx;
                  cnt_q <= CntW'(BIN_W);
                  ovf_q <= (64'(grant_op) > MaxVal);
                  ack_q <= NREQ'(1) << grant_idx;
               end
            end
            StShift: begin
               bin_q <= bin_sh;
               bcd_q <= bcd_sh;
               cnt_q <= cnt_q - CntW'(1);
               // Result registers are loaded on the last shift so they are
               // valid during DONE and hold until the next DONE.
               if (last_shift) begin
                  out_q    <= fmt;
                  bcd_id_q <= id_q;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
